// File: rtl/fact_accel_if.sv
// Bus bundle between the core's address decode and the factorial accelerator.
// master = core side, slave = accelerator side.
interface fact_accel_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  we;
  logic [1:0]            a;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] rd;
  logic                  busy;
  logic                  done;

  modport master (output we, a, wd, input rd, busy, done);
  modport slave  (input we, a, wd, output rd, busy, done);
endinterface

// File: rtl/fact_accel.sv
// Memory-mapped iterative factorial accelerator, one multiply per clock.
// Optional overflow rejection of N > MAX_N is enabled by defining FACT_OVF_CHECK_EN.
module fact_accel #(
  parameter int N_WIDTH    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_N      = 12
) (
  input  logic        clk,
  input  logic        rst,
  fact_accel_if.slave bus
);

  typedef enum logic {IDLE, MULT} state_t;

  state_t                        r_state;
  state_t                        w_stateNext;
  logic [N_WIDTH-1:0]            r_nReg;
  logic [N_WIDTH-1:0]            r_cnt;
  logic [DATA_WIDTH-1:0]         r_prod;
  logic [DATA_WIDTH-1:0]         r_result;
  logic                          r_done;
  logic                          w_err;
  logic                          w_busy;
  logic                          w_goAccept;
  logic                          w_ovf;
  logic                          w_finish;
  logic                          w_unusedBits;
  logic [DATA_WIDTH+N_WIDTH-1:0] w_fullProd;

  assign w_busy     = (r_state == MULT);
  assign w_goAccept = bus.we && (bus.a == 2'd1) && bus.wd[0] && (r_state == IDLE);
  assign w_finish   = w_busy && (r_cnt <= N_WIDTH'(1));
  assign w_fullProd = {{N_WIDTH{1'b0}}, r_prod} * {{DATA_WIDTH{1'b0}}, r_cnt};

  // Only the low operand bits and the GO bit of write data carry meaning.
  assign w_unusedBits = (^bus.wd[DATA_WIDTH-1:N_WIDTH]) ^ (MAX_N != 0);

`ifdef FACT_OVF_CHECK_EN
  logic r_err;

  assign w_ovf = (int'(r_nReg) > MAX_N);
  assign w_err = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_goAccept) begin
      r_err <= w_ovf;
    end
  end
`else
  assign w_ovf = 1'b0;
  assign w_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_goAccept && !w_ovf) w_stateNext = MULT;
      MULT:    if (w_finish) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // An overflowing GO completes on its own edge with a zero result and no multiply.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_nReg   <= '0;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      if (bus.we && (bus.a == 2'd0) && (r_state == IDLE)) begin
        r_nReg <= bus.wd[N_WIDTH-1:0];
      end
      if (w_goAccept) begin
        r_done <= w_ovf;
        if (w_ovf) begin
          r_result <= '0;
        end else begin
          r_cnt  <= r_nReg;
          r_prod <= DATA_WIDTH'(1);
        end
      end else if (w_busy) begin
        if (w_finish) begin
          r_result <= r_prod;
          r_done   <= 1'b1;
        end else begin
          r_prod <= w_fullProd[DATA_WIDTH-1:0];
          r_cnt  <= r_cnt - N_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    bus.rd = '0;
    case (bus.a)
      2'd0: bus.rd = DATA_WIDTH'(r_nReg);
      2'd1: bus.rd[0] = w_busy;
      2'd2: bus.rd[2:0] = {w_err, w_busy, r_done};
      2'd3: bus.rd = r_result;
    endcase
  end

  assign bus.busy = w_busy;
  assign bus.done = r_done;

endmodule

// File: doc/fact_accel.md
Name: fact_accel

Overview:
- Memory-mapped iterative factorial accelerator; a bus responder on the system's data-memory/peripheral address decode, beside the GPIO block.
- The MIPS core writes N and a GO strobe, polls STATUS, then reads RESULT.
- Computes N! with one multiply per clock, so software can offload factorial work done today in a loop.

Parameters:
- N_WIDTH, 4, width of operand register N.
- DATA_WIDTH, 32, width of bus data and result.
- MAX_N, 12, largest N whose factorial fits in DATA_WIDTH bits; used only by the optional overflow check.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- we  in  1  write enable, qualified by the address decode.
- a  in  2  word address: 0=N, 1=GO, 2=STATUS, 3=RESULT.
- wd  in  DATA_WIDTH  write data.
- rd  out  DATA_WIDTH  combinational read data for address a.
- busy  out  1  high while computing; mirrors STATUS[1].
- done  out  1  sticky completion flag; mirrors STATUS[0].

Behaviour:
- Reset (rst=0, async): state=IDLE, n_reg=0, cnt=0, prod=0, result=0, done=0, busy=0, err=0. Outputs are therefore 0 immediately.
- Read map:
  - a=0: zero-extended n_reg.
  - a=1: {0..., busy}.
  - a=2: {0..., err, busy, done}.
  - a=3: result.
  - rd is combinational and has no side effects.
- Write rules:
  - a=0 and IDLE: n_reg <= wd[N_WIDTH-1:0].
  - a=0 while busy: ignored.
  - a=2 or a=3: always ignored.
- States: IDLE, MULT.
- IDLE to MULT on an edge with we=1, a=1, wd[0]=1. At that edge: cnt<=n_reg, prod<=1, busy<=1, done<=0, err<=0.
- A GO write with wd[0]=0 is ignored. A GO write while busy is ignored, with no restart.
- Each MULT edge:
  - If cnt>1: prod <= prod*cnt, truncated to DATA_WIDTH; cnt <= cnt-1.
  - Otherwise: result<=prod, done<=1, busy<=0, state<=IDLE.
- Latency, counted in edges after the GO edge until done=1: max(N-1,0)+1. N=0 and N=1 take 1 edge and give result=1. N=5 takes 5 edges.
- result holds its previous value until the completing edge, so an early poll reads the stale result.
- done is sticky until the next accepted GO or reset.
- Multiply width: the full product is formed internally, then the low DATA_WIDTH bits are kept.
- Reset asserted mid-operation aborts immediately and returns to the reset state. No partial result is retained.
- A GO accepted on the edge right after done rises starts a new run normally.

Optional Feature:
- Macro: FACT_OVF_CHECK_EN.
- Defined, on an accepted GO with n_reg > MAX_N: state stays IDLE, err<=1, done<=1, result<=0, busy stays 0, and no multiply occurs. Latency is 1 edge.
- Defined, with n_reg <= MAX_N: behaviour is as above, with err=0.
- Undefined: err is tied to 0 and STATUS[2] reads 0. Every N is computed with wrap-around truncation.

Test Plan:
- Write N=5, then GO=1; poll STATUS -> busy=1 for 4 edges; done=1 on the 5th edge; RESULT=120 (0x78).
- N=0 and N=1, each followed by GO -> done after 1 edge, RESULT=1, err=0.
- N=12, GO -> done after 12 edges; RESULT=479001600 (0x1C8CFC00).
- N=13, GO:
  - Macro defined -> done after 1 edge, err=1, RESULT=0.
  - Macro undefined -> done after 13 edges, RESULT=0x7328CC00 (1932053504), STATUS[2]=0.
- N=6, GO; after 2 edges write N=3 and GO again -> both ignored; RESULT=720 when done; reading a=0 afterwards returns 6.
- N=10, GO; pull rst low for 3 ns at edge 4 -> rd at a=2 and a=3 reads 0 asynchronously. After release, N reads 0. A new run with N=4 gives RESULT=24.
